// File: rtl/pixel_norm_pkg.sv
// ============================================================================
// Module      : pixel_norm_pkg
// Description : Shared defaults and FSM state type for the pixel normaliser
//               (weighted-sum / weight-sum restoring divider).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pixel_norm_pkg;

    // Default operand and result widths
    localparam int c_NUM_W_DEF = 20;
    localparam int c_DEN_W_DEF = 12;
    localparam int c_PIX_W_DEF = 8;

    // Divider control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ITER  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage : pixel_norm_pkg

`default_nettype wire

// File: rtl/norm_div_step.sv
// ============================================================================
// Module      : norm_div_step
// Description : One restoring-division step. The divisor arrives already
//               aligned to the quotient bit being resolved; if the partial
//               remainder covers it, subtract and emit a 1, else pass the
//               remainder through and emit a 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module norm_div_step #(
    parameter int REM_W = 21,
    parameter int DIV_W = 20
) (
    input  logic [REM_W-1:0] i_rem,
    input  logic [DIV_W-1:0] i_div,
    output logic [REM_W-1:0] o_rem,
    output logic             o_qbit
);

    // Compare in a width that holds both operands without truncation
    localparam int c_CMP_W = (REM_W > DIV_W) ? REM_W : DIV_W;

    logic [c_CMP_W-1:0] w_rem_ext;
    logic [c_CMP_W-1:0] w_div_ext;
    logic [c_CMP_W-1:0] w_diff;
    logic               w_ge;

    assign w_rem_ext = c_CMP_W'(i_rem);
    assign w_div_ext = c_CMP_W'(i_div);
    assign w_ge      = (w_rem_ext >= w_div_ext);
    assign w_diff    = w_rem_ext - w_div_ext;

    // Restore (keep old remainder) when the aligned divisor does not fit;
    // when it fits the difference is smaller than i_rem, so it fits REM_W
    always_comb begin
        o_qbit = w_ge;
        o_rem  = i_rem;
        if (w_ge) begin
            o_rem = w_diff[REM_W-1:0];
        end
    end

endmodule : norm_div_step

`default_nettype wire

// File: rtl/pixel_norm_div.sv
// ============================================================================
// Module      : pixel_norm_div
// Description : Normalises a weighted pixel sum by its weight sum using a
//               multi-cycle restoring divider: one CHECK cycle for the
//               divide-by-zero and saturation tests, then PIX_W iterations
//               producing one quotient bit each, MSB first. Result is held
//               under a valid/ready handshake.
//               Build option: define PIXEL_NORM_DIV_ROUND_EN to round
//               half-up (numerator + floor(den/2)) instead of truncating.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_norm_div
    import pixel_norm_pkg::*;
#(
    parameter int NUM_W = c_NUM_W_DEF,
    parameter int DEN_W = c_DEN_W_DEF,
    parameter int PIX_W = c_PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] pix,
    output logic             sat,
    output logic             div_zero
);

    // Remainder carries one extra bit so the rounding bias cannot overflow
    localparam int c_REM_W = NUM_W + 1;
    // Divisor register is wide enough for den aligned to the quotient MSB
    localparam int c_DIV_W = DEN_W + PIX_W;
    localparam int c_CMP_W = (c_REM_W > c_DIV_W) ? c_REM_W : c_DIV_W;
    localparam int c_CNT_W = $clog2(PIX_W + 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e               r_state_q,    w_state_d;
    logic [NUM_W-1:0]     r_num_q,      w_num_d;
    logic [DEN_W-1:0]     r_den_q,      w_den_d;
    logic [c_REM_W-1:0]   r_rem_q,      w_rem_d;
    logic [c_DIV_W-1:0]   r_div_q,      w_div_d;
    logic [PIX_W-1:0]     r_quo_q,      w_quo_d;
    logic [c_CNT_W-1:0]   r_cnt_q,      w_cnt_d;
    logic                 r_sat_flag_q, w_sat_flag_d;
    logic                 r_dz_flag_q,  w_dz_flag_d;

    // Registered result outputs
    logic                 r_out_valid_q, w_out_valid_d;
    logic [PIX_W-1:0]     r_pix_q,       w_pix_d;
    logic                 r_sat_q,       w_sat_d;
    logic                 r_div_zero_q,  w_div_zero_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [c_REM_W-1:0]   w_num_adj;
    logic [c_CMP_W-1:0]   w_sat_lim;
    logic                 w_sat_hit;
    logic [c_REM_W-1:0]   w_step_rem;
    logic                 w_step_qbit;
    logic [PIX_W-1:0]     w_quo_next;
    logic                 w_last_iter;

`ifdef PIXEL_NORM_DIV_ROUND_EN
    // Round half-up: bias the numerator by half the divisor before dividing
    assign w_num_adj = c_REM_W'(r_num_q) + c_REM_W'(r_den_q >> 1);
`else
    // Truncating division: numerator used as received
    assign w_num_adj = c_REM_W'(r_num_q);
`endif

    // Quotient exceeds PIX_W bits exactly when numerator >= den * 2^PIX_W
    assign w_sat_lim = c_CMP_W'(r_den_q) << PIX_W;
    assign w_sat_hit = (c_CMP_W'(w_num_adj) >= w_sat_lim);

    // New quotient bit enters at the LSB; earlier bits move toward the MSB
    assign w_quo_next  = (r_quo_q << 1) | PIX_W'(w_step_qbit);
    assign w_last_iter = (r_cnt_q == c_CNT_W'(PIX_W - 1));

    // Single shared compare/subtract step, reused every ITER cycle
    norm_div_step #(
        .REM_W (c_REM_W),
        .DIV_W (c_DIV_W)
    ) u_step (
        .i_rem  (r_rem_q),
        .i_div  (r_div_q),
        .o_rem  (w_step_rem),
        .o_qbit (w_step_qbit)
    );

    // ------------------------------------------------------------------
    // Next-state and datapath update logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_num_d       = r_num_q;
        w_den_d       = r_den_q;
        w_rem_d       = r_rem_q;
        w_div_d       = r_div_q;
        w_quo_d       = r_quo_q;
        w_cnt_d       = r_cnt_q;
        w_sat_flag_d  = r_sat_flag_q;
        w_dz_flag_d   = r_dz_flag_q;
        w_out_valid_d = r_out_valid_q;
        w_pix_d       = r_pix_q;
        w_sat_d       = r_sat_q;
        w_div_zero_d  = r_div_zero_q;

        case (r_state_q)
            ST_IDLE: begin
                // Capture operands; later input changes cannot reach the
                // result because only these copies are used from here on
                if (in_valid) begin
                    w_num_d   = num;
                    w_den_d   = den;
                    w_state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                w_dz_flag_d  = (r_den_q == '0);
                w_sat_flag_d = (r_den_q != '0) && w_sat_hit;
                w_rem_d      = w_num_adj;
                w_div_d      = c_DIV_W'(r_den_q) << (PIX_W - 1);
                w_quo_d      = '0;
                w_cnt_d      = '0;
                w_state_d    = ST_ITER;
            end

            ST_ITER: begin
                // Iterations always run to completion so latency does not
                // depend on the operands, even when the result is overridden
                w_rem_d = w_step_rem;
                w_quo_d = w_quo_next;
                w_div_d = r_div_q >> 1;
                w_cnt_d = r_cnt_q + 1'b1;
                if (w_last_iter) begin
                    w_state_d     = ST_DONE;
                    w_out_valid_d = 1'b1;
                    w_sat_d       = r_sat_flag_q;
                    w_div_zero_d  = r_dz_flag_q;
                    if (r_dz_flag_q) begin
                        w_pix_d = '0;
                    end else if (r_sat_flag_q) begin
                        w_pix_d = '1;
                    end else begin
                        w_pix_d = w_quo_next;
                    end
                end
            end

            ST_DONE: begin
                // Hold the result until taken; return to IDLE without
                // accepting on the same edge
                if (out_ready) begin
                    w_state_d     = ST_IDLE;
                    w_out_valid_d = 1'b0;
                    w_pix_d       = '0;
                    w_sat_d       = 1'b0;
                    w_div_zero_d  = 1'b0;
                end
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers with synchronous reset; reset discards any operation
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_num_q       <= '0;
            r_den_q       <= '0;
            r_rem_q       <= '0;
            r_div_q       <= '0;
            r_quo_q       <= '0;
            r_cnt_q       <= '0;
            r_sat_flag_q  <= 1'b0;
            r_dz_flag_q   <= 1'b0;
            r_out_valid_q <= 1'b0;
            r_pix_q       <= '0;
            r_sat_q       <= 1'b0;
            r_div_zero_q  <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_num_q       <= w_num_d;
            r_den_q       <= w_den_d;
            r_rem_q       <= w_rem_d;
            r_div_q       <= w_div_d;
            r_quo_q       <= w_quo_d;
            r_cnt_q       <= w_cnt_d;
            r_sat_flag_q  <= w_sat_flag_d;
            r_dz_flag_q   <= w_dz_flag_d;
            r_out_valid_q <= w_out_valid_d;
            r_pix_q       <= w_pix_d;
            r_sat_q       <= w_sat_d;
            r_div_zero_q  <= w_div_zero_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (r_state_q == ST_IDLE);
    assign out_valid = r_out_valid_q;
    assign pix       = r_pix_q;
    assign sat       = r_sat_q;
    assign div_zero  = r_div_zero_q;

endmodule : pixel_norm_div

`default_nettype wire

// File: tb/tb_pixel_norm_div.sv
// ============================================================================
// Module      : tb_pixel_norm_div
// Description : Directed self-checking bench for pixel_norm_div with
//               hand-computed expected results for both rounding builds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_norm_div;
    import pixel_norm_pkg::*;

    localparam int NUM_W = c_NUM_W_DEF;
    localparam int DEN_W = c_DEN_W_DEF;
    localparam int PIX_W = c_PIX_W_DEF;
    localparam int LAT   = PIX_W + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [NUM_W-1:0] num;
    logic [DEN_W-1:0] den;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] pix;
    logic             sat;
    logic             div_zero;

    int n_vec  = 0;
    int n_miss = 0;

    pixel_norm_div #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W),
        .PIX_W (PIX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .den       (den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pix       (pix),
        .sat       (sat),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called #1 after the accepting edge; returns edges until out_valid
    // (99 if it never arrives). Optionally offers new operands mid-flight.
    task automatic wait_result(input bit noise, output int lat);
        lat = 99;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                lat = e;
                in_valid = 1'b0;
                break;
            end
            if (noise) begin
                chk("busy_no_accept", 32'(in_ready), 0);
                in_valid = (e >= 2 && e <= 6);
                num      = NUM_W'($urandom);
                den      = DEN_W'($urandom);
            end
        end
    endtask

    task automatic run_op(input string tag, input int n, input int d,
                          input int ep, input int es, input int ez, input bit noise);
        int lat;
        @(negedge clk);
        num      = NUM_W'(n);
        den      = DEN_W'(d);
        in_valid = 1'b1;
        chk({tag, "_ready"}, 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(in_ready), 0);
        wait_result(noise, lat);
        chk({tag, "_lat"}, lat, LAT);
        chk({tag, "_pix"}, 32'(pix), ep);
        chk({tag, "_sat"}, 32'(sat), es);
        chk({tag, "_dz"},  32'(div_zero), ez);
        @(posedge clk); #1;
        chk({tag, "_idle"},  32'(in_ready), 1);
        chk({tag, "_vdrop"}, 32'(out_valid), 0);
    endtask

    initial begin
        int lat;
        int stale;
        rst       = 1'b1;
        in_valid  = 1'b0;
        num       = '0;
        den       = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_pix",   32'(pix), 0);
        chk("rst_sat",   32'(sat), 0);
        chk("rst_dz",    32'(div_zero), 0);
        @(negedge clk);
        rst = 1'b0;

        // 2295/9 = 255 exactly; rounded 2299 < 2304 still 255
        run_op("q255", 2295, 9, 255, 0, 0, 1'b0);
`ifdef PIXEL_NORM_DIV_ROUND_EN
        run_op("q1004", 1004, 9, 112, 0, 0, 1'b0);
        run_op("edge2303", 2303, 9, 255, 1, 0, 1'b0);
        run_op("noise", 1000, 7, 143, 0, 0, 1'b1);
`else
        run_op("q1004", 1004, 9, 111, 0, 0, 1'b0);
        run_op("edge2303", 2303, 9, 255, 0, 0, 1'b0);
        run_op("noise", 1000, 7, 142, 0, 0, 1'b1);
`endif
        run_op("sat5000", 5000, 9, 255, 1, 0, 1'b0);
        run_op("edge2304", 2304, 9, 255, 1, 0, 1'b0);
        run_op("divzero", 123, 0, 0, 0, 1, 1'b0);
        run_op("den1", 255, 1, 255, 0, 0, 1'b0);
        run_op("zero", 0, 5, 0, 0, 0, 1'b0);

        // Back-pressure: hold DONE for 5 cycles, then a queued second pair
        @(negedge clk);
        out_ready = 1'b0;
        num       = NUM_W'(600);
        den       = DEN_W'(5);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(1'b0, lat);
        chk("stall_lat", lat, LAT);
        chk("stall_pix", 32'(pix), 120);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_hold_valid", 32'(out_valid), 1);
            chk("stall_hold_pix",   32'(pix), 120);
            chk("stall_hold_ready", 32'(in_ready), 0);
            num      = NUM_W'(2550);
            den      = DEN_W'(10);
            in_valid = 1'b1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_idle",  32'(in_ready), 1);
        chk("release_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        chk("second_accept", 32'(in_ready), 0);
        in_valid = 1'b0;
        wait_result(1'b0, lat);
        chk("second_lat", lat, LAT);
        chk("second_pix", 32'(pix), 255);
        chk("second_sat", 32'(sat), 0);
        @(posedge clk); #1;

        // Reset during the 4th ITER cycle discards the operation
        @(negedge clk);
        num      = NUM_W'(5000);
        den      = DEN_W'(9);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_ready", 32'(in_ready), 1);
        chk("midrst_pix",   32'(pix), 0);
        chk("midrst_sat",   32'(sat), 0);
        stale = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale++;
        end
        chk("midrst_no_stale", stale, 0);

        // Normal operation resumes after the discarded one
        run_op("post_rst", 1004, 4, 251, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_pixel_norm_div

`default_nettype wire

// File: doc/pixel_norm_div.md
PIXEL_NORM_DIV -- requirements
Module: pixel_norm_div

Interface
REQ-001 Parameter NUM_W, default 20, width of the weighted pixel-sum numerator.
REQ-002 Parameter DEN_W, default 12, width of the weight-sum denominator.
REQ-003 Parameter PIX_W, default 8, width of the output pixel.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  num/den valid.
REQ-007 in_ready  output  1  block can accept a new operand pair.
REQ-008 num  input  NUM_W  unsigned weighted sum from the window adder tree.
REQ-009 den  input  DEN_W  unsigned sum of weights.
REQ-010 out_valid  output  1  pix/sat/div_zero valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 pix  output  PIX_W  normalised pixel, floor(num/den) or rounded (REQ-026).
REQ-013 sat  output  1  quotient clipped to 2^PIX_W-1.
REQ-014 div_zero  output  1  den was zero.

Function
REQ-015 The FSM SHALL have states IDLE, CHECK, ITER and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; an accept is in_valid&&in_ready at a rising edge, and it registers num/den and moves the FSM to CHECK.
REQ-017 After an accept, later changes on num/den and in_valid SHALL NOT affect the result in flight.
REQ-018 CHECK SHALL last 1 cycle: set div_zero if den==0; otherwise set sat if the numerator (adjusted per REQ-026) >= den<<PIX_W; then enter ITER.
REQ-019 ITER SHALL last exactly PIX_W cycles of restoring shift-subtract, with one quotient bit per cycle from MSB to LSB, even when sat or div_zero is set.
REQ-020 out_valid SHALL rise exactly PIX_W+1 rising edges after the accepting edge (9 for defaults).
REQ-021 Results SHALL be pix=0 when div_zero, pix=2^PIX_W-1 when sat, and the computed quotient otherwise; sat and div_zero are never both 1.
REQ-022 DONE SHALL hold out_valid, pix, sat and div_zero stable until out_ready is 1; DONE&&out_ready returns to IDLE on that edge.
REQ-023 A new input SHALL NOT be accepted on the edge that leaves DONE, so the minimum accept-to-accept interval is PIX_W+3 cycles.
REQ-024 Internal remainder width SHALL be NUM_W+1 bits, so no intermediate value overflows.

Reset
REQ-025 When rst is high at an edge, including mid-CHECK/ITER/DONE, the FSM SHALL go to IDLE and set out_valid=0, pix=0, sat=0, div_zero=0 and in_ready=1 on the next cycle; the in-flight operation is discarded.

Configuration
REQ-026 With PIXEL_NORM_DIV_ROUND_EN defined, CHECK SHALL replace the numerator with num+floor(den/2) (round-half-up), and saturation tests the adjusted value.
REQ-027 Without PIXEL_NORM_DIV_ROUND_EN, the numerator SHALL be used unmodified (truncating division); latency is identical in both builds.

Structure
REQ-028 Package pixel_norm_pkg SHALL hold the NUM_W/DEN_W/PIX_W defaults and the state enum type.
REQ-029 One sub-module norm_div_step SHALL implement a single compare/subtract/shift step (remainder in, divisor in, remainder out, quotient bit out), instantiated once and reused each ITER cycle.

Verification
REQ-030 num=2295, den=9 -> pix=255, sat=0, div_zero=0, out_valid exactly 9 edges after accept (both builds).
REQ-031 num=1004, den=9 -> pix=111 without ROUND_EN; pix=112 with ROUND_EN.
REQ-032 num=5000, den=9 -> pix=255, sat=1; num=123, den=0 -> pix=0, div_zero=1, sat=0, same 9-edge latency.
REQ-033 out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0; out_ready=1 -> IDLE next edge, and a second operand pair offered with in_valid held high is accepted on the following edge.
REQ-034 rst pulsed for 1 cycle during the 4th ITER cycle -> next cycle out_valid=0, in_ready=1, pix=0; no stale result ever appears.
REQ-035 in_valid toggled with new num/den values while in ITER -> no accept, and the result matches the originally accepted operands.
